// File: rtl/mpg_sd_arbiter.sv
// mpg_sd_arbiter: shares one hps_io sd block-read channel between
// the video (client 0) and audio (client 1) sector streamers.
module mpg_sd_arbiter #(
  parameter int                  TO_WIDTH    = 24,
  parameter logic [TO_WIDTH-1:0] REQ_TIMEOUT = 24'd16000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] c0_lba,
  input  logic        c0_rd,
  output logic        c0_ack,
  output logic        c0_buff_wr,
  input  logic [31:0] c1_lba,
  input  logic        c1_rd,
  output logic        c1_ack,
  output logic        c1_buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic        grant_id,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_GAP
  } state_t;

  localparam logic [TO_WIDTH-1:0] WD_LAST = REQ_TIMEOUT - 1'b1;

  state_t              state_q, state_d;
  logic [31:0]         sd_lba_q, sd_lba_d;
  logic                sd_rd_q, sd_rd_d;
  logic                grant_q, grant_d;
  logic                discard_q, discard_d;
  logic                last_q, last_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                terr_q, terr_d;

  logic grant_rd;
  logic pick1;
  logic fwd;

  assign grant_rd = grant_q ? c1_rd : c0_rd;
  // Client 1 wins alone, or on a tie when client 0 was served last.
  assign pick1    = c1_rd & (~c0_rd | ~last_q);

  always_comb begin
    state_d   = state_q;
    sd_lba_d  = sd_lba_q;
    sd_rd_d   = sd_rd_q;
    grant_d   = grant_q;
    discard_d = discard_q;
    last_d    = last_q;
    wd_d      = wd_q;
    terr_d    = terr_q & ~err_clr;
    unique case (state_q)
      S_IDLE: begin
        if (!sd_ack && (c0_rd || c1_rd)) begin
          sd_lba_d  = pick1 ? c1_lba : c0_lba;
          sd_rd_d   = 1'b1;
          grant_d   = pick1;
          discard_d = 1'b0;
          wd_d      = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (!grant_rd) discard_d = 1'b1;
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          state_d = S_XFER;
        end else if (wd_q == WD_LAST) begin
          sd_rd_d = 1'b0;
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          last_d  = grant_q;
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sd_lba_q  <= '0;
      sd_rd_q   <= 1'b0;
      grant_q   <= 1'b0;
      discard_q <= 1'b0;
      last_q    <= 1'b1;
      wd_q      <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_lba_q  <= sd_lba_d;
      sd_rd_q   <= sd_rd_d;
      grant_q   <= grant_d;
      discard_q <= discard_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      terr_q    <= terr_d;
    end
  end

  assign fwd = (state_q == S_REQ || state_q == S_XFER) & ~discard_q;

  assign c0_ack      = sd_ack & fwd & ~grant_q;
  assign c1_ack      = sd_ack & fwd & grant_q;
  assign c0_buff_wr  = sd_buff_wr & fwd & ~grant_q;
  assign c1_buff_wr  = sd_buff_wr & fwd & grant_q;
  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mpg_sd_arbiter.sv
// tb_mpg_sd_arbiter: randomized bench with a transaction-level
// model of grant order, LBA routing and strobe forwarding.
module tb_mpg_sd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] c0_lba, c1_lba;
  logic        c0_rd, c1_rd;
  logic        c0_ack, c1_ack;
  logic        c0_buff_wr, c1_buff_wr;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic        grant_id;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  int n_chk  = 0;
  int n_fail = 0;
  int s0 = 0;
  int s1 = 0;
  int fwd_to = -1;
  int last_srv = 1;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  mpg_sd_arbiter #(
    .TO_WIDTH   (24),
    .REQ_TIMEOUT(24'd100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .c0_lba     (c0_lba),
    .c0_rd      (c0_rd),
    .c0_ack     (c0_ack),
    .c0_buff_wr (c0_buff_wr),
    .c1_lba     (c1_lba),
    .c1_rd      (c1_rd),
    .c1_ack     (c1_ack),
    .c1_buff_wr (c1_buff_wr),
    .sd_lba     (sd_lba),
    .sd_rd      (sd_rd),
    .sd_ack     (sd_ack),
    .sd_buff_wr (sd_buff_wr),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner of the current transfer sees the ack; nobody else ever does.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("c0_ack", c0_ack, sd_ack && fwd_to == 0);
      chk("c1_ack", c1_ack, sd_ack && fwd_to == 1);
      chk("c0_bwr", c0_buff_wr, sd_ack && sd_buff_wr && fwd_to == 0);
      chk("c1_bwr", c1_buff_wr, sd_ack && sd_buff_wr && fwd_to == 1);
      if (c0_buff_wr) s0++;
      if (c1_buff_wr) s1++;
    end
  end

  function automatic int pick(bit p0, bit p1, int ls);
    if (p0 && p1) return (ls == 0) ? 1 : 0;
    return p0 ? 0 : 1;
  endfunction

  task automatic reset_dut();
    reset      = 1'b1;
    c0_rd      = 1'b0;
    c1_rd      = 1'b0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    err_clr    = 1'b0;
    fwd_to     = -1;
    tick();
    tick();
    reset    = 1'b0;
    last_srv = 1;
  endtask

  // HPS side of one sector: wait for sd_rd, ack, stream, release.
  task automatic hps_xfer(input int g, input logic [31:0] lba,
                          input int nstr, input int fwd, input bit drop);
    int k;
    int b0;
    int b1;
    int d;
    k = 0;
    while (sd_rd !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("rd_rise", sd_rd, 1);
    chk("grant_id", grant_id, g);
    chk("sd_lba", sd_lba, lba);
    chk("busy_req", busy, 1);
    d = $urandom_range(0, 4);
    repeat (d) tick();
    chk("rd_hold", sd_rd, 1);
    chk("lba_hold", sd_lba, lba);
    b0 = s0;
    b1 = s1;
    fwd_to = fwd;
    sd_ack = 1'b1;
    tick();
    chk("rd_fall", sd_rd, 0);
    if (drop) begin
      if (g == 0) c0_rd = 1'b0;
      else c1_rd = 1'b0;
    end
    for (int i = 0; i < nstr + 7; i++) begin
      sd_buff_wr = (i >= 4 && i < nstr + 4);
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    tick();
    chk("gap_busy", busy, 1);
    chk("gap_rd", sd_rd, 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_rd", sd_rd, 0);
    fwd_to = -1;
    chk("c0_strobes", s0 - b0, (fwd == 0) ? nstr : 0);
    chk("c1_strobes", s1 - b1, (fwd == 1) ? nstr : 0);
    last_srv = g;
  endtask

  initial begin
    int n;
    int g;
    logic [31:0] la;
    logic [31:0] lb;
    c0_lba = '0;
    c1_lba = '0;
    reset_dut();
    mon_en = 1'b1;
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);

    // single request, full 512-byte sector
    c0_lba = 32'h10;
    c0_rd  = 1'b1;
    tick();
    chk("single_rd", sd_rd, 1);
    chk("single_lba", sd_lba, 32'h10);
    hps_xfer(0, 32'h10, 512, 0, 1'b1);

    // simultaneous requests held continuously: strict alternation
    reset_dut();
    c0_lba = $urandom;
    c1_lba = $urandom;
    c0_rd  = 1'b1;
    c1_rd  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      g = pick(1'b1, 1'b1, last_srv);
      hps_xfer(g, g ? c1_lba : c0_lba, $urandom_range(1, 12), g, 1'b0);
    end
    c0_rd = 1'b0;
    c1_rd = 1'b0;
    tick();

    // random request mixes
    for (int it = 0; it < 20; it++) begin
      int p;
      bit p0;
      bit p1;
      p  = $urandom_range(1, 3);
      p0 = p[0];
      p1 = p[1];
      c0_lba = $urandom;
      c1_lba = $urandom;
      c0_rd  = p0;
      c1_rd  = p1;
      while (p0 || p1) begin
        g = pick(p0, p1, last_srv);
        hps_xfer(g, g ? c1_lba : c0_lba, $urandom_range(0, 16), g, 1'b1);
        if (g == 0) p0 = 1'b0;
        else p1 = 1'b0;
      end
    end

    // watchdog: err_clr held through the timeout, set must win
    reset_dut();
    la      = $urandom;
    c0_lba  = la;
    c0_rd   = 1'b1;
    err_clr = 1'b1;
    tick();
    n = 0;
    while (sd_rd === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    chk("wd_cycles", n, 100);
    chk("wd_terr_set", timeout_err, 1);
    chk("wd_busy", busy, 0);
    last_srv = 0;
    err_clr = 1'b0;
    tick();
    chk("wd_rearb", sd_rd, 1);
    chk("wd_terr_hold", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_terr_clr", timeout_err, 0);
    hps_xfer(0, la, 8, 0, 1'b1);
    chk("wd_terr_after", timeout_err, 0);

    // discard: client 1 withdraws before ack, client 0 waits
    reset_dut();
    la     = $urandom;
    lb     = $urandom;
    c0_lba = la;
    c1_lba = lb;
    c1_rd  = 1'b1;
    tick();
    chk("disc_grant", grant_id, 1);
    c1_rd = 1'b0;
    c0_rd = 1'b1;
    tick();
    hps_xfer(1, lb, 20, -1, 1'b0);
    hps_xfer(0, la, 10, 0, 1'b1);

    // reset in the middle of a transfer
    reset_dut();
    la     = $urandom;
    c0_lba = la;
    c0_rd  = 1'b1;
    tick();
    chk("mid_rd", sd_rd, 1);
    fwd_to = 0;
    sd_ack = 1'b1;
    tick();
    repeat (3) begin
      sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    fwd_to = -1;
    last_srv = 1;
    chk("mid_sd_rd", sd_rd, 0);
    chk("mid_sd_lba", sd_lba, 0);
    chk("mid_busy", busy, 0);
    chk("mid_grant", grant_id, 0);
    chk("mid_c0_ack", c0_ack, 0);
    n = s0;
    for (int i = 0; i < 10; i++) begin
      sd_buff_wr = i[0];
      tick();
      chk("mid_no_grant", sd_rd, 0);
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    chk("mid_swallow", s0 - n, 0);
    tick();
    chk("mid_regrant", sd_rd, 1);
    hps_xfer(0, la, 6, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
